// File: rtl/runtime_cfg_ctrl.sv
// Runtime ISA extension-enable controller: validates change requests, drains the pipeline, applies them.
// Optional flush timeout is built in when RUNTIME_CFG_TIMEOUT_EN is defined.

package config_pkg;

   typedef struct packed {
      logic RVA;
      logic RVB;
      logic RVC;
      logic RVF;
      logic RVD;
      logic RVV;
      logic RVH;
      logic ZKN;
      logic CvxifEn;
   } cva6_cfg_t;

   localparam cva6_cfg_t cva6_cfg_empty = '{default: 1'b0};

endpackage

module runtime_cfg_ctrl #(
   parameter config_pkg::cva6_cfg_t CVA6Cfg        = config_pkg::cva6_cfg_empty,
   parameter int unsigned           NrExt          = 10,
   parameter logic [NrExt-1:0]      CustomCapMask  = '0,
   parameter int unsigned           QuiesceTimeout = 64
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic [NrExt-1:0] req_ext_i,
   output logic             flush_o,
   input  logic             idle_i,
   output logic             rsp_valid_o,
   input  logic             rsp_ready_i,
   output logic [1:0]       rsp_err_o,
   output logic [NrExt-1:0] ext_en_o,
   output logic             fp_present_o,
   output logic [6:0]       flen_o,
   output logic [2:0]       nr_wb_ports_o,
   output logic [7:0]       cfg_gen_o
);

   // Bits 0..7 come from the core configuration; the mask supplies custom bits above.
   function automatic logic [NrExt-1:0] build_cap();
      logic [NrExt-1:0] c;
      c    = CustomCapMask;
      c[0] = CVA6Cfg.RVA;
      c[1] = CVA6Cfg.RVB;
      c[2] = CVA6Cfg.RVC;
      c[3] = CVA6Cfg.RVF;
      c[4] = CVA6Cfg.RVD;
      c[5] = CVA6Cfg.RVV;
      c[6] = CVA6Cfg.RVH;
      c[7] = CVA6Cfg.ZKN;
      return c;
   endfunction

   function automatic logic [6:0] calc_flen(input logic d_en, input logic f_en);
      logic [6:0] f;
      if (d_en) begin
         f = 7'd64;
      end else if (f_en) begin
         f = 7'd32;
      end else begin
         f = 7'd0;
      end
      return f;
   endfunction

   function automatic logic calc_fp(input logic d_en, input logic f_en);
      return d_en | f_en;
   endfunction

   function automatic logic [2:0] calc_nr_wb(input logic v_en);
      return (v_en || CVA6Cfg.CvxifEn) ? 3'd5 : 3'd4;
   endfunction

   localparam logic [NrExt-1:0] Cap = build_cap();

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FLUSH = 2'd1,
      APPLY = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t           state_r;
   state_t           state_s;
   logic             ready_r;
   logic             flush_r;
   logic             rsp_valid_r;
   logic [1:0]       err_r;
   logic [1:0]       err_s;
   logic [NrExt-1:0] req_r;
   logic [NrExt-1:0] ext_r;
   logic             fp_r;
   logic [6:0]       flen_r;
   logic [2:0]       nr_wb_r;
   logic [7:0]       gen_r;
   logic             illegal_s;
   logic             same_s;
   logic             timeout_s;

   assign illegal_s = (|(req_ext_i & ~Cap)) || (req_ext_i[4] && !req_ext_i[3]);
   assign same_s    = (req_ext_i == ext_r);

`ifdef RUNTIME_CFG_TIMEOUT_EN
   localparam int unsigned CntW = (QuiesceTimeout > 1) ? $clog2(QuiesceTimeout + 1) : 1;

   logic [CntW-1:0] cnt_r;

   // Counts cycles spent in FLUSH; cleared whenever the FSM is elsewhere.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_r <= '0;
      end else if (state_r != FLUSH) begin
         cnt_r <= '0;
      end else begin
         cnt_r <= cnt_r + CntW'(1'b1);
      end
   end

   assign timeout_s = (state_r == FLUSH) && (cnt_r == CntW'(QuiesceTimeout - 32'd1));
`else
   assign timeout_s = 1'b0;
`endif

   // Next-state and response code selection.
   always_comb begin
      state_s = state_r;
      err_s   = err_r;
      case (state_r)
         IDLE: begin
            if (req_valid_i) begin
               if (illegal_s) begin
                  state_s = RESP;
                  err_s   = 2'd1;
               end else if (same_s) begin
                  state_s = RESP;
                  err_s   = 2'd0;
               end else begin
                  state_s = FLUSH;
                  err_s   = 2'd0;
               end
            end else begin
               state_s = IDLE;
            end
         end
         FLUSH: begin
            // A drained pipeline wins over a timeout hitting in the same cycle.
            if (idle_i) begin
               state_s = APPLY;
            end else if (timeout_s) begin
               state_s = RESP;
               err_s   = 2'd2;
            end else begin
               state_s = FLUSH;
            end
         end
         APPLY: begin
            state_s = RESP;
            err_s   = 2'd0;
         end
         RESP: begin
            if (rsp_ready_i) begin
               state_s = IDLE;
               err_s   = 2'd0;
            end else begin
               state_s = RESP;
            end
         end
         default: begin
            state_s = IDLE;
            err_s   = 2'd0;
         end
      endcase
   end

   // State register and handshake outputs, all registered from the next state.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r     <= IDLE;
         ready_r     <= 1'b1;
         flush_r     <= 1'b0;
         rsp_valid_r <= 1'b0;
         err_r       <= 2'd0;
      end else begin
         state_r     <= state_s;
         ready_r     <= (state_s == IDLE);
         flush_r     <= (state_s == FLUSH);
         rsp_valid_r <= (state_s == RESP);
         err_r       <= err_s;
      end
   end

   // Captured request and the active configuration with its derived views.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         req_r   <= Cap;
         ext_r   <= Cap;
         fp_r    <= calc_fp(Cap[4], Cap[3]);
         flen_r  <= calc_flen(Cap[4], Cap[3]);
         nr_wb_r <= calc_nr_wb(Cap[5]);
         gen_r   <= 8'd0;
      end else begin
         if ((state_r == IDLE) && req_valid_i) begin
            req_r <= req_ext_i;
         end
         if (state_r == APPLY) begin
            ext_r   <= req_r;
            fp_r    <= calc_fp(req_r[4], req_r[3]);
            flen_r  <= calc_flen(req_r[4], req_r[3]);
            nr_wb_r <= calc_nr_wb(req_r[5]);
            gen_r   <= gen_r + 8'd1;
         end
      end
   end

   assign req_ready_o   = ready_r;
   assign flush_o       = flush_r;
   assign rsp_valid_o   = rsp_valid_r;
   assign rsp_err_o     = err_r;
   assign ext_en_o      = ext_r;
   assign fp_present_o  = fp_r;
   assign flen_o        = flen_r;
   assign nr_wb_ports_o = nr_wb_r;
   assign cfg_gen_o     = gen_r;

endmodule

// File: tb/tb_runtime_cfg_ctrl.sv
// Directed, table-driven bench for runtime_cfg_ctrl on a core with A,C,F,D,Zkn and custom bit 8.
// Covers both builds: with and without RUNTIME_CFG_TIMEOUT_EN.

module tb_runtime_cfg_ctrl;

   localparam int unsigned NrExt = 10;
   localparam logic [NrExt-1:0] CustomMask = 10'b01_0000_0000;
   localparam config_pkg::cva6_cfg_t TbCfg = '{RVA: 1'b1, RVB: 1'b0, RVC: 1'b1, RVF: 1'b1,
                                               RVD: 1'b1, RVV: 1'b0, RVH: 1'b0, ZKN: 1'b1,
                                               CvxifEn: 1'b0};
   // A(0) C(2) F(3) D(4) Zkn(7) custom(8)
   localparam logic [NrExt-1:0] CapExp = 10'h19D;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             req_valid;
   logic             req_ready;
   logic [NrExt-1:0] req_ext;
   logic             flush;
   logic             idle;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [1:0]       rsp_err;
   logic [NrExt-1:0] ext_en;
   logic             fp_present;
   logic [6:0]       flen;
   logic [2:0]       nr_wb_ports;
   logic [7:0]       cfg_gen;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   runtime_cfg_ctrl #(
      .CVA6Cfg       (TbCfg),
      .NrExt         (NrExt),
      .CustomCapMask (CustomMask),
      .QuiesceTimeout(8)
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .req_valid_i  (req_valid),
      .req_ready_o  (req_ready),
      .req_ext_i    (req_ext),
      .flush_o      (flush),
      .idle_i       (idle),
      .rsp_valid_o  (rsp_valid),
      .rsp_ready_i  (rsp_ready),
      .rsp_err_o    (rsp_err),
      .ext_en_o     (ext_en),
      .fp_present_o (fp_present),
      .flen_o       (flen),
      .nr_wb_ports_o(nr_wb_ports),
      .cfg_gen_o    (cfg_gen)
   );

   typedef struct {
      logic [NrExt-1:0] req;
      int               idle_after;
      logic [1:0]       err;
      int               nflush;
      logic [NrExt-1:0] ext;
      logic [6:0]       flen;
      logic             fp;
      logic [7:0]       gen;
   } vec_t;

   vec_t vecs[9];
   logic [NrExt-1:0] model_ext;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_cfg(input string tag, input logic [NrExt-1:0] e, input logic [6:0] fl,
                            input logic fp, input logic [7:0] g);
      check({tag, "_ext"}, 32'(ext_en), 32'(e));
      check({tag, "_flen"}, 32'(flen), 32'(fl));
      check({tag, "_fp"}, 32'(fp_present), 32'(fp));
      check({tag, "_nrwb"}, 32'(nr_wb_ports), 32'd4);
      check({tag, "_gen"}, 32'(cfg_gen), 32'(g));
   endtask

   // Holds the response one extra cycle, then completes the handshake.
   task automatic finish_rsp(input logic [1:0] exp_err);
      @(negedge clk);
      check("rsp_hold_valid", 32'(rsp_valid), 32'd1);
      check("rsp_hold_err", 32'(rsp_err), 32'(exp_err));
      check("rsp_ready_low", 32'(req_ready), 32'd0);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      @(negedge clk);
      check("rsp_done_valid", 32'(rsp_valid), 32'd0);
      check("rsp_done_err", 32'(rsp_err), 32'd0);
      check("rsp_done_ready", 32'(req_ready), 32'd1);
   endtask

   task automatic run_txn(input vec_t v, input logic [NrExt-1:0] prev_ext);
      int cyc;
      int nflush;
      @(negedge clk);
      check("ready_idle", 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_ext   = v.req;
      idle      = 1'b1;  // must be ignored during the accept cycle
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      idle      = 1'b0;
      cyc       = 0;
      nflush    = 0;
      while (cyc < 300) begin
         @(negedge clk);
         cyc++;
         if (rsp_valid) break;
         if (cyc == 1) begin
            check("ready_busy", 32'(req_ready), 32'd0);
            check("ext_hold", 32'(ext_en), 32'(prev_ext));
         end
         if (flush) begin
            nflush++;
            if (nflush == v.idle_after) idle = 1'b1;
         end
      end
      idle = 1'b0;
      check("rsp_valid", 32'(rsp_valid), 32'd1);
      check("rsp_err", 32'(rsp_err), 32'(v.err));
      check("flush_cycles", 32'(nflush), 32'(v.nflush));
      check("latency", 32'(cyc), (v.nflush == 0) ? 32'd1 : 32'(v.nflush + 2));
      check_cfg("txn", v.ext, v.flen, v.fp, v.gen);
      finish_rsp(v.err);
   endtask

   initial begin
      int cyc;
      int nflush;
      vec_t w;

      vecs[0] = '{10'h18D, 3, 2'd0, 3, 10'h18D, 7'd32, 1'b1, 8'd1};  // drop D
      vecs[1] = '{10'h1AD, 0, 2'd1, 0, 10'h18D, 7'd32, 1'b1, 8'd1};  // V not supported
      vecs[2] = '{10'h195, 0, 2'd1, 0, 10'h18D, 7'd32, 1'b1, 8'd1};  // D without F
      vecs[3] = '{10'h18D, 0, 2'd0, 0, 10'h18D, 7'd32, 1'b1, 8'd1};  // same as current
      vecs[4] = '{10'h185, 1, 2'd0, 1, 10'h185, 7'd0,  1'b0, 8'd2};  // drop F
      vecs[5] = '{10'h19D, 2, 2'd0, 2, 10'h19D, 7'd64, 1'b1, 8'd3};  // full cap
      vecs[6] = '{10'h39D, 0, 2'd1, 0, 10'h19D, 7'd64, 1'b1, 8'd3};  // custom bit 9 absent
      vecs[7] = '{10'h002, 0, 2'd1, 0, 10'h19D, 7'd64, 1'b1, 8'd3};  // B absent
      vecs[8] = '{10'h000, 1, 2'd0, 1, 10'h000, 7'd0,  1'b0, 8'd4};  // everything off

      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_ext   = '0;
      idle      = 1'b0;
      rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_flush", 32'(flush), 32'd0);
      check("rst_rspv", 32'(rsp_valid), 32'd0);
      check("rst_err", 32'(rsp_err), 32'd0);
      check_cfg("rst", CapExp, 7'd64, 1'b1, 8'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_ready", 32'(req_ready), 32'd1);
      check_cfg("post_rst", CapExp, 7'd64, 1'b1, 8'd0);

      model_ext = CapExp;
      for (int i = 0; i < 9; i++) begin
         run_txn(vecs[i], model_ext);
         model_ext = vecs[i].ext;
      end

      @(negedge clk);
      req_valid = 1'b1;
      req_ext   = CapExp;
      idle      = 1'b0;
      @(posedge clk);
      #1 req_valid = 1'b0;
`ifdef RUNTIME_CFG_TIMEOUT_EN
      cyc    = 0;
      nflush = 0;
      while (cyc < 50) begin
         @(negedge clk);
         cyc++;
         if (rsp_valid) break;
         if (flush) nflush++;
      end
      check("to_flush_cycles", 32'(nflush), 32'd8);
      check("to_valid", 32'(rsp_valid), 32'd1);
      check("to_err", 32'(rsp_err), 32'd2);
      check("to_flush_low", 32'(flush), 32'd0);
      check_cfg("to", 10'h000, 7'd0, 1'b0, 8'd4);
      finish_rsp(2'd2);
      @(negedge clk);
      req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (5) @(negedge clk);
`else
      nflush = 0;
      repeat (1000) begin
         @(negedge clk);
         if (flush && !rsp_valid) nflush++;
      end
      check("noto_flush_1000", 32'(nflush), 32'd1000);
`endif
      check("pre_rst_flush", 32'(flush), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_flush", 32'(flush), 32'd0);
      check("mid_rst_rspv", 32'(rsp_valid), 32'd0);
      check("mid_rst_ready", 32'(req_ready), 32'd1);
      check_cfg("mid_rst", CapExp, 7'd64, 1'b1, 8'd0);
      @(negedge clk);
      rst_n = 1'b1;
      idle  = 1'b1;
      nflush = 0;
      repeat (5) begin
         @(negedge clk);
         if (rsp_valid || flush) nflush++;
      end
      idle = 1'b0;
      check("no_rsp_after_rst", 32'(nflush), 32'd0);

      model_ext = CapExp;
      for (int k = 1; k <= 256; k++) begin
         w.req        = ((k % 2) == 1) ? 10'h18D : 10'h19D;
         w.idle_after = 1;
         w.err        = 2'd0;
         w.nflush     = 1;
         w.ext        = w.req;
         w.flen       = ((k % 2) == 1) ? 7'd32 : 7'd64;
         w.fp         = 1'b1;
         w.gen        = 8'(k);
         run_txn(w, model_ext);
         model_ext = w.ext;
      end
      check("gen_wrap", 32'(cfg_gen), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/runtime_cfg_ctrl.md
RUNTIME_CFG_CTRL -- requirements
Module: runtime_cfg_ctrl

Interface
REQ-001 Parameter CVA6Cfg, config_pkg::cva6_cfg_t default config_pkg::cva6_cfg_empty; compile-time capability source.
REQ-002 Parameter NrExt, int unsigned, default 10, minimum 8; number of runtime extension-enable bits.
REQ-003 Parameter CustomCapMask, logic [NrExt-1:0], default '0; capability of bits 8..NrExt-1.
REQ-004 Parameter QuiesceTimeout, int unsigned, default 64; maximum cycles waiting for pipeline idle.
REQ-005 clk_i  input  1  single clock, rising edge.
REQ-006 rst_ni  input  1  reset, asynchronous, active-low.
REQ-007 req_valid_i  input  1  config-change request valid.
REQ-008 req_ready_o  output  1  request accepted when both valid and ready are high.
REQ-009 req_ext_i  input  NrExt  requested extension-enable vector.
REQ-010 flush_o  output  1  pipeline drain request.
REQ-011 idle_i  input  1  pipeline drained, no instruction in flight.
REQ-012 rsp_valid_o  output  1  response valid.
REQ-013 rsp_ready_i  input  1  response consumed.
REQ-014 rsp_err_o  output  2  0 ok, 1 illegal, 2 timeout.
REQ-015 ext_en_o  output  NrExt  active extension enables; bit0 A, 1 B, 2 C, 3 F, 4 D, 5 V, 6 H, 7 Zkn, 8+ custom.
REQ-016 fp_present_o  output  1  F or D active.
REQ-017 flen_o  output  7  64 if D active, else 32 if F active, else 0.
REQ-018 nr_wb_ports_o  output  3  5 if V active or CVA6Cfg.CvxifEn, else 4.
REQ-019 cfg_gen_o  output  8  count of applied changes.

Function
REQ-020 Capability mask cap = {CustomCapMask[NrExt-1:8], CVA6Cfg.ZKN, RVH, RVV, RVD, RVF, RVC, RVB, RVA}.
REQ-021 States: IDLE, FLUSH, APPLY, RESP.
REQ-022 req_ready_o SHALL be high only in IDLE.
REQ-023 On accept, request SHALL be registered; illegal if (req & ~cap) != 0 or (D set and F clear) -> RESP with err 1, no flush, outputs unchanged.
REQ-024 Legal request equal to ext_en_o -> RESP with err 0 next cycle, no flush, cfg_gen_o unchanged.
REQ-025 Other legal request -> FLUSH; flush_o high throughout FLUSH only.
REQ-026 In FLUSH, idle_i high -> APPLY next cycle; idle_i sampled high in the accept cycle is ignored.
REQ-027 APPLY lasts one cycle: ext_en_o, derived outputs and cfg_gen_o+1 update at its end; then RESP err 0.
REQ-028 Derived outputs SHALL be registered and change only in the same cycle as ext_en_o.
REQ-029 cfg_gen_o wraps 255 -> 0.
REQ-030 RESP holds rsp_valid_o and rsp_err_o stable until rsp_ready_i; then IDLE; back-to-back request accepted the following cycle at earliest.
REQ-031 rsp_valid_o low outside RESP; rsp_err_o SHALL be 0 whenever rsp_valid_o is low.

Reset
REQ-032 rst_ni low, at any state: state IDLE, flush_o 0, rsp_valid_o 0, rsp_err_o 0, cfg_gen_o 0, ext_en_o = cap, derived outputs computed from cap.
REQ-033 A request in flight at reset is dropped without response.

Configuration
REQ-034 Macro RUNTIME_CFG_TIMEOUT_EN defined: FLUSH counts cycles; after QuiesceTimeout cycles without idle_i, flush_o drops, RESP with err 2, config unchanged.
REQ-035 Macro undefined: no counter; FLUSH waits indefinitely; err 2 never produced.

Verification
REQ-036 Reset with RVF=RVD=RVC=1, RVV=0, CvxifEn=0 -> ext_en_o=cap, flen_o=64, fp_present_o=1, nr_wb_ports_o=4, cfg_gen_o=0.
REQ-037 Request clearing D (F kept), idle_i high 3 cycles after accept -> flush_o high 3 cycles, flen_o=32 after APPLY, rsp err 0, cfg_gen_o=1.
REQ-038 Request setting V on core without RVV -> rsp err 1, flush_o never high, outputs unchanged.
REQ-039 Request D=1 F=0 -> err 1; request equal to current -> err 0, no flush, cfg_gen_o unchanged.
REQ-040 With RUNTIME_CFG_TIMEOUT_EN, QuiesceTimeout=8, idle_i held 0 -> err 2 after 8 FLUSH cycles; without macro, flush_o stays high 1000 cycles.
REQ-041 rst_ni asserted mid-FLUSH -> flush_o 0 immediately, reset values restored, no response issued; 256 applied changes -> cfg_gen_o wraps to 0.
